// File: rtl/edge_pkg.sv
// Shared definitions for the edge threshold / statistics block:
// default geometry, coordinate widths, the stats record and the FSM states.
package edge_pkg;

   localparam int IMG_W_DEF = 512;
   localparam int IMG_H_DEF = 512;
   localparam int MAG_W_DEF = 12;
   localparam int CNT_W_DEF = 18;
   localparam int X_W_DEF   = $clog2(IMG_W_DEF);
   localparam int Y_W_DEF   = $clog2(IMG_H_DEF);

   // Per-frame statistics as seen by the rover's obstacle/feature logic
   // when the block is built with the default geometry.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] count;
      logic                 no_edges;
      logic [X_W_DEF-1:0]   xmin;
      logic [X_W_DEF-1:0]   xmax;
      logic [Y_W_DEF-1:0]   ymin;
      logic [Y_W_DEF-1:0]   ymax;
   } edge_stats_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      REPORT = 2'd2
   } edge_state_t;

endpackage

// File: rtl/edge_bbox_tracker.sv
// Running edge statistics for one frame: saturating edge count plus the
// bounding box of all edge pixels. The first edge after a clear loads the
// box directly, so a clear and an edge in the same cycle start a new frame.
import edge_pkg::*;

module edge_bbox_tracker #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int X_W   = X_W_DEF,
   parameter int Y_W   = Y_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic             i_isEdge,
   input  logic [X_W-1:0]   i_x,
   input  logic [Y_W-1:0]   i_y,
   output logic [CNT_W-1:0] o_count,
   output logic [X_W-1:0]   o_xmin,
   output logic [X_W-1:0]   o_xmax,
   output logic [Y_W-1:0]   o_ymin,
   output logic [Y_W-1:0]   o_ymax
);

   logic [CNT_W-1:0] r_count;
   logic             r_hasEdge;
   logic [X_W-1:0]   r_xmin;
   logic [X_W-1:0]   r_xmax;
   logic [Y_W-1:0]   r_ymin;
   logic [Y_W-1:0]   r_ymax;

   // Accumulate count and min/max on edge pixels; a clear wins unless an
   // edge arrives with it, in which case that edge seeds the new frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= '0;
         r_hasEdge <= 1'b0;
         r_xmin    <= '0;
         r_xmax    <= '0;
         r_ymin    <= '0;
         r_ymax    <= '0;
      end else if (i_en && i_isEdge) begin
         if (i_clear || !r_hasEdge) begin
            r_count   <= CNT_W'(1);
            r_hasEdge <= 1'b1;
            r_xmin    <= i_x;
            r_xmax    <= i_x;
            r_ymin    <= i_y;
            r_ymax    <= i_y;
         end else begin
            if (!(&r_count)) r_count <= r_count + CNT_W'(1);
            if (i_x < r_xmin) r_xmin <= i_x;
            if (i_x > r_xmax) r_xmax <= i_x;
            if (i_y < r_ymin) r_ymin <= i_y;
            if (i_y > r_ymax) r_ymax <= i_y;
         end
      end else if (i_clear) begin
         r_count   <= '0;
         r_hasEdge <= 1'b0;
         r_xmin    <= '0;
         r_xmax    <= '0;
         r_ymin    <= '0;
         r_ymax    <= '0;
      end
   end

   assign o_count = r_count;
   assign o_xmin  = r_xmin;
   assign o_xmax  = r_xmax;
   assign o_ymin  = r_ymin;
   assign o_ymax  = r_ymax;

endmodule

// File: rtl/edge_thresh_stats.sv
// Binarises the Sobel magnitude stream against a threshold latched at
// start-of-frame and reports per-frame edge count and bounding box.
// Optional macro EDGE_HYST_EN adds a low threshold (thresh_lo) so that a
// pixel between the two thresholds is an edge when its left neighbour was.
import edge_pkg::*;

module edge_thresh_stats #(
   parameter  int IMG_W = IMG_W_DEF,
   parameter  int IMG_H = IMG_H_DEF,
   parameter  int MAG_W = MAG_W_DEF,
   parameter  int CNT_W = CNT_W_DEF,
   localparam int X_W   = $clog2(IMG_W),
   localparam int Y_W   = $clog2(IMG_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MAG_W-1:0] in_mag,
   input  logic             in_sop,
   input  logic             in_eop,
   input  logic [MAG_W-1:0] thresh,
`ifdef EDGE_HYST_EN
   input  logic [MAG_W-1:0] thresh_lo,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_edge,
   output logic             out_sop,
   output logic             out_eop,
   output logic             stats_valid,
   output logic [CNT_W-1:0] edge_count,
   output logic             no_edges,
   output logic [X_W-1:0]   bbox_xmin,
   output logic [X_W-1:0]   bbox_xmax,
   output logic [Y_W-1:0]   bbox_ymin,
   output logic [Y_W-1:0]   bbox_ymax
);

   edge_state_t      r_state;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic [MAG_W-1:0] r_thrHi;
   logic             r_outValid;
   logic             r_outEdge;
   logic             r_outSop;
   logic             r_outEop;
   logic             r_statsValid;
   logic [CNT_W-1:0] r_edgeCount;
   logic             r_noEdges;
   logic [X_W-1:0]   r_xmin;
   logic [X_W-1:0]   r_xmax;
   logic [Y_W-1:0]   r_ymin;
   logic [Y_W-1:0]   r_ymax;

   logic             w_accept;
   logic             w_start;
   logic             w_process;
   logic [X_W-1:0]   w_x;
   logic [Y_W-1:0]   w_y;
   logic [MAG_W-1:0] w_thrHi;
   logic             w_isEdge;
   logic             w_trkClear;
   logic [CNT_W-1:0] w_trkCount;
   logic [X_W-1:0]   w_trkXmin;
   logic [X_W-1:0]   w_trkXmax;
   logic [Y_W-1:0]   w_trkYmin;
   logic [Y_W-1:0]   w_trkYmax;

`ifdef EDGE_HYST_EN
   logic [MAG_W-1:0] r_thrLo;
   logic             r_prevEdge;
   logic [MAG_W-1:0] w_thrLo;
   logic             w_prevEdge;
`endif

   // Single output register: a new sample fits whenever the slot is empty
   // or is being drained this cycle; the report cycle takes no input.
   assign in_ready  = (r_state != REPORT) && (!r_outValid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_start   = w_accept && in_sop;
   assign w_process = w_accept && (in_sop || (r_state == ACTIVE));

   // A start-of-frame pixel is always (0,0) and uses the threshold
   // presented with it, not the stale latched one.
   assign w_x     = in_sop ? '0 : r_x;
   assign w_y     = in_sop ? '0 : r_y;
   assign w_thrHi = in_sop ? thresh : r_thrHi;
`ifdef EDGE_HYST_EN
   assign w_thrLo    = in_sop ? thresh_lo : r_thrLo;
   assign w_prevEdge = (in_sop || (w_x == '0)) ? 1'b0 : r_prevEdge;
`endif

   // Edge decision for the pixel being accepted; with hysteresis a weak
   // pixel continues an edge run from its left neighbour on the same line.
   always_comb begin
      w_isEdge = (in_mag >= w_thrHi);
`ifdef EDGE_HYST_EN
      if (!w_isEdge && w_prevEdge && (in_mag >= w_thrLo)) w_isEdge = 1'b1;
`endif
   end

   // Accumulators restart on every accepted sop (new or aborted frame)
   // and after their contents have been copied out in REPORT.
   assign w_trkClear = w_start || (r_state == REPORT);

   edge_bbox_tracker #(
      .CNT_W (CNT_W),
      .X_W   (X_W),
      .Y_W   (Y_W)
   ) u_tracker (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_trkClear),
      .i_en     (w_process),
      .i_isEdge (w_isEdge),
      .i_x      (w_x),
      .i_y      (w_y),
      .o_count  (w_trkCount),
      .o_xmin   (w_trkXmin),
      .o_xmax   (w_trkXmax),
      .o_ymin   (w_trkYmin),
      .o_ymax   (w_trkYmax)
   );

   // Frame FSM plus everything it owns: raster position, latched
   // thresholds, the output register and the registered stats outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_thrHi      <= '0;
         r_outValid   <= 1'b0;
         r_outEdge    <= 1'b0;
         r_outSop     <= 1'b0;
         r_outEop     <= 1'b0;
         r_statsValid <= 1'b0;
         r_edgeCount  <= '0;
         r_noEdges    <= 1'b0;
         r_xmin       <= '0;
         r_xmax       <= '0;
         r_ymin       <= '0;
         r_ymax       <= '0;
`ifdef EDGE_HYST_EN
         r_thrLo      <= '0;
         r_prevEdge   <= 1'b0;
`endif
      end else begin
         r_statsValid <= 1'b0;

         if (w_process) begin
            r_outValid <= 1'b1;
            r_outEdge  <= w_isEdge;
            r_outSop   <= in_sop;
            r_outEop   <= in_eop;
            if (w_x == X_W'(IMG_W - 1)) begin
               r_x <= '0;
               r_y <= (w_y == Y_W'(IMG_H - 1)) ? w_y : w_y + Y_W'(1);
            end else begin
               r_x <= w_x + X_W'(1);
               r_y <= w_y;
            end
            if (in_sop) r_thrHi <= thresh;
`ifdef EDGE_HYST_EN
            if (in_sop) r_thrLo <= thresh_lo;
            r_prevEdge <= w_isEdge;
`endif
         end else if (out_ready) begin
            r_outValid <= 1'b0;
         end

         case (r_state)
            IDLE, ACTIVE: begin
               if (w_process) r_state <= in_eop ? REPORT : ACTIVE;
            end
            REPORT: begin
               r_statsValid <= 1'b1;
               r_edgeCount  <= w_trkCount;
               r_noEdges    <= (w_trkCount == '0);
               r_xmin       <= (w_trkCount == '0) ? '0 : w_trkXmin;
               r_xmax       <= (w_trkCount == '0) ? '0 : w_trkXmax;
               r_ymin       <= (w_trkCount == '0) ? '0 : w_trkYmin;
               r_ymax       <= (w_trkCount == '0) ? '0 : w_trkYmax;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid   = r_outValid;
   assign out_edge    = r_outEdge;
   assign out_sop     = r_outSop;
   assign out_eop     = r_outEop;
   assign stats_valid = r_statsValid;
   assign edge_count  = r_edgeCount;
   assign no_edges    = r_noEdges;
   assign bbox_xmin   = r_xmin;
   assign bbox_xmax   = r_xmax;
   assign bbox_ymin   = r_ymin;
   assign bbox_ymax   = r_ymax;

endmodule
